// File: rtl/radiant_readout_sequencer_if.sv
// Handshake and status bundle between the readout sequencer and its environment.
interface radiant_readout_sequencer_if;
  localparam int unsigned INFO_W = 16;
  localparam int unsigned HDR_W  = 48;
  localparam int unsigned OCC_W  = 4;
  localparam int unsigned DROP_W = 16;

  logic              run_i;
  logic              trig_i;
  logic [INFO_W-1:0] trig_info_i;
  logic [1:0]        nseq_i;
  logic              hdr_valid_o;
  logic              hdr_ready_i;
  logic [HDR_W-1:0]  hdr_data_o;
  logic              seq_req_o;
  logic              seq_ack_i;
  logic              seq_done_i;
  logic              evt_consumed_i;
  logic              readout_running_o;
  logic              readout_done_o;
  logic              readout_full_o;
  logic [OCC_W-1:0]  occupancy_o;
  logic [DROP_W-1:0] dropped_o;

  // Sequencer side
  modport master (
    input  run_i, trig_i, trig_info_i, nseq_i, hdr_ready_i,
           seq_ack_i, seq_done_i, evt_consumed_i,
    output hdr_valid_o, hdr_data_o, seq_req_o, readout_running_o,
           readout_done_o, readout_full_o, occupancy_o, dropped_o
  );

  // Environment side (trigger source, header sink, LAB4 controller, DMA)
  modport slave (
    output run_i, trig_i, trig_info_i, nseq_i, hdr_ready_i,
           seq_ack_i, seq_done_i, evt_consumed_i,
    input  hdr_valid_o, hdr_data_o, seq_req_o, readout_running_o,
           readout_done_o, readout_full_o, occupancy_o, dropped_o
  );
endinterface

// File: rtl/radiant_readout_sequencer.sv
// RADIANT readout sequencer: trigger -> header -> N LAB4 readout sequences -> done,
// with event-occupancy tracking and a saturating dropped-trigger counter.
module radiant_readout_sequencer #(
  parameter int unsigned MAX_EVENTS = 4
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_n_i,
  radiant_readout_sequencer_if.master   bus
);

  localparam int unsigned OCC_W  = 4;
  localparam int unsigned DROP_W = 16;
  localparam int unsigned EVT_W  = 32;
  localparam int unsigned HDR_W  = 48;
  localparam int unsigned CNT_W  = 2;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_HEADER    = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_nseq;
  logic [CNT_W-1:0]  r_seq_cnt;
  logic [EVT_W-1:0]  r_evt_num;
  logic [HDR_W-1:0]  r_hdr_data;
  logic [OCC_W-1:0]  r_occ;
  logic [DROP_W-1:0] r_dropped;
  logic              r_running;
  logic              r_done;
  logic              r_hdr_valid;
  logic              r_seq_req;

  logic w_full;
  logic w_accept;
  logic w_drop;
  logic w_inc;
  logic w_dec;
  logic w_last;

  assign w_full   = (r_occ == OCC_W'(MAX_EVENTS));
  assign w_accept = (r_state == S_IDLE) && bus.trig_i && bus.run_i && !w_full;
  assign w_drop   = bus.trig_i && !w_accept;
  assign w_inc    = (r_state == S_DONE);
  assign w_dec    = bus.evt_consumed_i && (r_occ != '0);
  assign w_last   = (r_seq_cnt == r_nseq);

  // Next-state logic; dropping run aborts any in-flight event
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_HEADER;
      end
      S_HEADER: begin
        if (!bus.run_i)          w_state_nxt = S_IDLE;
        else if (bus.hdr_ready_i) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (!bus.run_i)        w_state_nxt = S_IDLE;
        else if (bus.seq_ack_i) w_state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!bus.run_i)         w_state_nxt = S_IDLE;
        else if (bus.seq_done_i) w_state_nxt = w_last ? S_DONE : S_REQ;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  // Registered strobes decoded from the upcoming state so they align with it
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_hdr_valid <= 1'b0;
      r_seq_req   <= 1'b0;
      r_done      <= 1'b0;
      r_running   <= 1'b0;
    end else begin
      r_hdr_valid <= (w_state_nxt == S_HEADER);
      r_seq_req   <= (w_state_nxt == S_REQ);
      r_done      <= (w_state_nxt == S_DONE);
      r_running   <= bus.run_i;
    end
  end

  // Trigger capture and per-event sequence counting
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_hdr_data <= '0;
      r_nseq     <= '0;
      r_seq_cnt  <= '0;
    end else if (w_accept) begin
      r_hdr_data <= {r_evt_num, bus.trig_info_i};
      r_nseq     <= bus.nseq_i;
      r_seq_cnt  <= '0;
    end else if ((r_state == S_WAIT_DONE) && bus.run_i && bus.seq_done_i && !w_last) begin
      r_seq_cnt  <= r_seq_cnt + CNT_W'(1);
    end
  end

  // Event number advances once per completed event, wrapping at 32 bits
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i)   r_evt_num <= '0;
    else if (w_inc)     r_evt_num <= r_evt_num + EVT_W'(1);
  end

  // Occupancy: completed events in, consumed events out; simultaneous cancels
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_occ <= '0;
    end else begin
      case ({w_inc, w_dec})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Saturating count of triggers that could not start an event
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i)                            r_dropped <= '0;
    else if (w_drop && (r_dropped != '1))        r_dropped <= r_dropped + DROP_W'(1);
  end

  assign bus.hdr_valid_o       = r_hdr_valid;
  assign bus.hdr_data_o        = r_hdr_data;
  assign bus.seq_req_o         = r_seq_req;
  assign bus.readout_running_o = r_running;
  assign bus.readout_done_o    = r_done;
  assign bus.readout_full_o    = w_full;
  assign bus.occupancy_o       = r_occ;
  assign bus.dropped_o         = r_dropped;

endmodule

// File: tb/tb_radiant_readout_sequencer.sv
// Self-checking bench for radiant_readout_sequencer: directed scenarios plus
// randomized events checked against an event-level reference model.
module tb_radiant_readout_sequencer;

  localparam int MAX_EV = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  radiant_readout_sequencer_if bus();

  radiant_readout_sequencer #(.MAX_EVENTS(MAX_EV)) dut (
    .sys_clk_i   (clk),
    .sys_rst_n_i (rst_n),
    .bus         (bus)
  );

  // Reference model state: event-level bookkeeping only
  logic [31:0] m_evt;
  int          m_occ;
  int          m_drop;
  int          m_done_total;

  int n_pass   = 0;
  int n_checks = 0;

  int hs_cnt     = 0;
  int done_cnt   = 0;
  int mutex_viol = 0;

  // Bus observers
  always @(posedge clk) begin
    if (bus.seq_req_o && bus.seq_ack_i)   hs_cnt     <= hs_cnt + 1;
    if (bus.readout_done_o)               done_cnt   <= done_cnt + 1;
    if (bus.hdr_valid_o && bus.seq_req_o) mutex_viol <= mutex_viol + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_inc();
    if (m_drop < 65535) m_drop++;
  endtask

  task automatic model_reset();
    m_evt  = '0;
    m_occ  = 0;
    m_drop = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_hdr_valid"}, 64'(bus.hdr_valid_o), 64'(0));
    check_eq({tag, "_seq_req"},   64'(bus.seq_req_o), 64'(0));
    check_eq({tag, "_done"},      64'(bus.readout_done_o), 64'(0));
    check_eq({tag, "_full"},      64'(bus.readout_full_o), 64'(0));
    check_eq({tag, "_running"},   64'(bus.readout_running_o), 64'(0));
    check_eq({tag, "_occ"},       64'(bus.occupancy_o), 64'(0));
    check_eq({tag, "_dropped"},   64'(bus.dropped_o), 64'(0));
    check_eq({tag, "_hdr_data"},  64'(bus.hdr_data_o), 64'(0));
  endtask

  task automatic consume_pulse();
    bus.evt_consumed_i = 1'b1;
    tick();
    bus.evt_consumed_i = 1'b0;
    if (m_occ > 0) m_occ--;
    check_eq("consume_occ", 64'(bus.occupancy_o), 64'(m_occ));
    check_eq("consume_full", 64'(bus.readout_full_o), 64'(m_occ == MAX_EV));
  endtask

  // Full event: trigger, header handshake, nseq+1 sequence handshakes, done
  task automatic run_event(input logic [15:0] info, input logic [1:0] nseq,
                           input int rdy_dly, input int ack_dly, input int done_dly,
                           input bit consume_in_done, input bit mid_trig);
    logic [47:0] exp_hdr;
    int          hs0;
    bit          ok;
    exp_hdr = {m_evt, info};
    hs0     = hs_cnt;
    bus.trig_info_i = info;
    bus.nseq_i      = nseq;
    bus.trig_i      = 1'b1;
    tick();
    bus.trig_i      = 1'b0;
    bus.trig_info_i = 16'($urandom);
    bus.nseq_i      = 2'($urandom);
    check_eq("hdr_valid_lat", 64'(bus.hdr_valid_o), 64'(1));
    check_eq("hdr_data", 64'(bus.hdr_data_o), 64'(exp_hdr));
    ok = 1'b1;
    for (int i = 0; i < rdy_dly; i++) begin
      if (mid_trig && i == 0) bus.trig_i = 1'b1;
      tick();
      bus.trig_i = 1'b0;
      if (mid_trig && i == 0) drop_inc();
      if (!bus.hdr_valid_o || bus.hdr_data_o !== exp_hdr || bus.seq_req_o) ok = 1'b0;
    end
    check_eq("hdr_hold", 64'(ok), 64'(1));
    bus.hdr_ready_i = 1'b1;
    tick();
    bus.hdr_ready_i = 1'b0;
    for (int s = 0; s <= int'(nseq); s++) begin
      check_eq("seq_req_up", 64'({bus.hdr_valid_o, bus.seq_req_o}), 64'(2'b01));
      ok = 1'b1;
      for (int i = 0; i < ack_dly; i++) begin
        bus.seq_done_i = 1'($urandom_range(0, 1));
        tick();
        if (!bus.seq_req_o) ok = 1'b0;
      end
      bus.seq_done_i = 1'b0;
      check_eq("seq_req_hold", 64'(ok), 64'(1));
      bus.seq_ack_i = 1'b1;
      tick();
      bus.seq_ack_i = 1'b0;
      check_eq("seq_req_drop", 64'(bus.seq_req_o), 64'(0));
      for (int i = 0; i < done_dly; i++) begin
        bus.seq_ack_i = 1'($urandom_range(0, 1));
        tick();
      end
      bus.seq_ack_i  = 1'b0;
      bus.seq_done_i = 1'b1;
      tick();
      bus.seq_done_i = 1'b0;
    end
    check_eq("done_lat", 64'(bus.readout_done_o), 64'(1));
    if (consume_in_done) bus.evt_consumed_i = 1'b1;
    tick();
    bus.evt_consumed_i = 1'b0;
    if (!(consume_in_done && m_occ > 0)) m_occ++;
    m_evt = m_evt + 32'd1;
    m_done_total++;
    check_eq("done_pulse_end", 64'(bus.readout_done_o), 64'(0));
    check_eq("evt_occ", 64'(bus.occupancy_o), 64'(m_occ));
    check_eq("evt_full", 64'(bus.readout_full_o), 64'(m_occ == MAX_EV));
    check_eq("evt_hs", 64'(hs_cnt - hs0), 64'(int'(nseq) + 1));
    check_eq("evt_dropped", 64'(bus.dropped_o), 64'(m_drop));
  endtask

  task automatic trig_run_low();
    bus.run_i = 1'b0;
    tick();
    check_eq("running_low", 64'(bus.readout_running_o), 64'(0));
    bus.trig_i = 1'b1;
    tick();
    bus.trig_i = 1'b0;
    drop_inc();
    check_eq("runlow_no_hdr", 64'(bus.hdr_valid_o), 64'(0));
    check_eq("runlow_dropped", 64'(bus.dropped_o), 64'(m_drop));
    bus.run_i = 1'b1;
    tick();
    check_eq("running_high", 64'(bus.readout_running_o), 64'(1));
  endtask

  initial begin
    bus.run_i          = 1'b0;
    bus.trig_i         = 1'b0;
    bus.trig_info_i    = '0;
    bus.nseq_i         = '0;
    bus.hdr_ready_i    = 1'b0;
    bus.seq_ack_i      = 1'b0;
    bus.seq_done_i     = 1'b0;
    bus.evt_consumed_i = 1'b0;
    rst_n              = 1'b0;
    model_reset();
    m_done_total = 0;

    #12;
    check_zero_outputs("reset");
    #10;
    rst_n     = 1'b1;
    bus.run_i = 1'b1;
    tick();
    check_eq("running_after_rst", 64'(bus.readout_running_o), 64'(1));

    // Basic event: header {0, 0x0015}, three sequences
    run_event(16'h0015, 2'd2, 0, 0, 0, 1'b0, 1'b0);

    // Header back-pressure for 10 cycles, with a stray trigger while busy
    run_event(16'h1234, 2'd1, 10, 2, 1, 1'b0, 1'b1);

    // Consume coincident with DONE at occupancy 2 leaves occupancy unchanged
    run_event(16'hbeef, 2'd0, 1, 1, 1, 1'b1, 1'b0);
    consume_pulse();
    consume_pulse();
    consume_pulse();

    // Randomized events with random interludes
    for (int e = 0; e < 40; e++) begin
      if (m_occ == MAX_EV) consume_pulse();
      case ($urandom_range(0, 3))
        0: consume_pulse();
        1: begin
          bus.seq_done_i = 1'b1;
          tick();
          bus.seq_done_i = 1'b0;
          check_eq("stray_done", 64'(bus.readout_done_o), 64'(0));
        end
        2: trig_run_low();
        default: tick();
      endcase
      run_event(16'($urandom), 2'($urandom_range(0, 3)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Abort in WAIT_DONE by dropping run; number is reused by the next event
    if (m_occ == MAX_EV) consume_pulse();
    bus.trig_info_i = 16'h00ab;
    bus.nseq_i      = 2'd1;
    bus.trig_i      = 1'b1;
    tick();
    bus.trig_i      = 1'b0;
    bus.hdr_ready_i = 1'b1;
    tick();
    bus.hdr_ready_i = 1'b0;
    bus.seq_ack_i   = 1'b1;
    tick();
    bus.seq_ack_i   = 1'b0;
    bus.run_i       = 1'b0;
    tick();
    check_eq("abort_done", 64'(bus.readout_done_o), 64'(0));
    check_eq("abort_idle", 64'({bus.hdr_valid_o, bus.seq_req_o}), 64'(0));
    check_eq("abort_occ", 64'(bus.occupancy_o), 64'(m_occ));
    bus.run_i = 1'b1;
    tick();
    run_event(16'h00cd, 2'd1, 0, 0, 0, 1'b0, 1'b0);

    // Asynchronous reset while a sequence request is pending
    if (m_occ == MAX_EV) consume_pulse();
    bus.trig_i = 1'b1;
    tick();
    bus.trig_i      = 1'b0;
    bus.hdr_ready_i = 1'b1;
    tick();
    bus.hdr_ready_i = 1'b0;
    check_eq("pre_rst_req", 64'(bus.seq_req_o), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    #10;
    rst_n = 1'b1;
    model_reset();
    tick();

    // Fill to MAX_EVENTS, drop a trigger while full, then drain one
    for (int e = 0; e < MAX_EV; e++)
      run_event(16'($urandom), 2'($urandom_range(0, 3)), 0, 0, 0, 1'b0, 1'b0);
    check_eq("full_set", 64'(bus.readout_full_o), 64'(1));
    bus.trig_i = 1'b1;
    tick();
    bus.trig_i = 1'b0;
    drop_inc();
    check_eq("full_no_hdr", 64'(bus.hdr_valid_o), 64'(0));
    check_eq("full_dropped", 64'(bus.dropped_o), 64'(m_drop));
    tick();
    check_eq("full_no_hdr2", 64'(bus.hdr_valid_o), 64'(0));
    consume_pulse();
    run_event(16'h5a5a, 2'd3, 1, 0, 2, 1'b0, 1'b0);

    check_eq("hdr_req_mutex", 64'(mutex_viol), 64'(0));
    check_eq("done_pulses", 64'(done_cnt), 64'(m_done_total));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
